// File: rtl/lenet_pkg.sv
// lenet_pkg: shared LeNet constants, FC-layer FSM state and the output saturator.
package lenet_pkg;
  localparam int F6_N_IN = 120;
  localparam int F6_N_OUT = 84;
  localparam int DATA_W = 8;
  localparam int F6_ACC_W = 24;
  localparam int F6_SHIFT = 7;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} fc_state_t;
  // Arithmetic rescale, then clamp to the signed 8-bit range.
  function automatic logic [DATA_W-1:0] sat8(input logic signed [F6_ACC_W-1:0] v);
    logic signed [F6_ACC_W-1:0] s;
    s = v >>> F6_SHIFT;
    return s > 24'sd127 ? 8'h7f : s < -24'sd128 ? 8'h80 : s[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/f6_mac_lane.sv
// f6_mac_lane: one signed 8x8 multiply-accumulator with synchronous clear and enable.
// Ports: clk, rst (async, active-high), clr (zero acc), en (accumulate w*a), w/a operands, acc sum.
module f6_mac_lane
  import lenet_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   w,
  input  logic signed [DATA_W-1:0]   a,
  output logic signed [F6_ACC_W-1:0] acc
);
  logic signed [2*DATA_W-1:0] p;
  assign p = w * a;
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= clr ? '0 : en ? acc + F6_ACC_W'(p) : acc;
endmodule

// File: rtl/f6_mac_array.sv
// f6_mac_array: F6 fully-connected engine, 120 rows x 84 parallel MAC lanes, streamed 8-bit results.
// Ports: start/busy/done control; w6_raddr/w6_rdata weight ROM; c5_raddr/c5_rdata activations;
// f6_valid/f6_ready/f6_idx/f6_data output stream to F7.
module f6_mac_array
  import lenet_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [6:0]                 w6_raddr,
  input  logic [F6_N_OUT*DATA_W-1:0] w6_rdata,
  output logic [6:0]                 c5_raddr,
  input  logic [DATA_W-1:0]          c5_rdata,
  output logic                       f6_valid,
  input  logic                       f6_ready,
  output logic [6:0]                 f6_idx,
  output logic [DATA_W-1:0]          f6_data
);
  fc_state_t state;
  logic vld, dr, clr;
  logic [6:0] nxt;
  logic signed [F6_ACC_W-1:0] acc [F6_N_OUT];
  assign busy = state != IDLE;
  assign c5_raddr = w6_raddr;
  assign clr = state == IDLE && start;
  assign nxt = f6_idx + 7'd1;
  for (genvar i = 0; i < F6_N_OUT; i++) begin : g_lane
    f6_mac_lane u_lane (
      .clk(clk), .rst(rst), .clr(clr), .en(vld),
      .w(w6_rdata[DATA_W*i +: DATA_W]), .a(c5_rdata), .acc(acc[i])
    );
  end
  // vld trails the issued address by one cycle, matching the 1-cycle read latency;
  // OUT holds for the done cycle so a start there is ignored.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      w6_raddr <= '0;
      vld <= 1'b0;
      dr <= 1'b0;
      done <= 1'b0;
      f6_valid <= 1'b0;
      f6_idx <= '0;
      f6_data <= '0;
    end else begin
      done <= 1'b0;
      vld <= state == RUN;
      case (state)
        IDLE: if (start) begin
          w6_raddr <= '0;
          state <= RUN;
        end
        RUN: if (w6_raddr == 7'(F6_N_IN - 1)) begin
          dr <= 1'b0;
          state <= DRAIN;
        end else w6_raddr <= w6_raddr + 7'd1;
        DRAIN: begin
          dr <= 1'b1;
          if (dr) begin
            state <= OUT;
            f6_valid <= 1'b1;
            f6_idx <= '0;
            f6_data <= sat8(acc[0]);
          end
        end
        OUT: if (done) state <= IDLE;
        else if (f6_valid && f6_ready) begin
          if (f6_idx == 7'(F6_N_OUT - 1)) begin
            f6_valid <= 1'b0;
            done <= 1'b1;
          end else begin
            f6_idx <= nxt;
            f6_data <= sat8(acc[nxt]);
          end
        end
      endcase
    end
endmodule

// File: tb/tb_f6_mac_array.sv
// tb_f6_mac_array: directed self-checking bench for f6_mac_array.
module tb_f6_mac_array;
  import lenet_pkg::*;
  logic clk = 0, rst = 0, start = 0, f6_ready = 0;
  logic busy, done, f6_valid;
  logic [6:0] w6_raddr, c5_raddr, f6_idx;
  logic [7:0] f6_data, c5_rdata;
  logic [F6_N_OUT*DATA_W-1:0] w6_rdata;
  logic [7:0] wt [84];
  logic [7:0] act [120];
  logic signed [7:0] got [84];
  int checks = 0, failures = 0;
  int nbeats, order_err, stall_err, done_cyc, first_valid, beats_at_done;
  logic busy_at_done;

  always #5 clk = ~clk;

  f6_mac_array dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w6_raddr(w6_raddr), .w6_rdata(w6_rdata), .c5_raddr(c5_raddr), .c5_rdata(c5_rdata),
    .f6_valid(f6_valid), .f6_ready(f6_ready), .f6_idx(f6_idx), .f6_data(f6_data)
  );

  always @(posedge clk) begin
    for (int j = 0; j < 84; j++) w6_rdata[8*j +: 8] <= wt[j];
    c5_rdata <= act[c5_raddr];
  end

  task automatic set_mode(input int m);
    for (int j = 0; j < 84; j++)
      wt[j] = m == 0 ? 8'd1 : m == 1 ? 8'd127 : m == 2 ? 8'h80 : 8'(j - 42);
    for (int k = 0; k < 120; k++)
      act[k] = m == 0 ? 8'd1 : m <= 2 ? 8'd127 : m == 3 ? 8'd1 : (k == 0 || k == 119) ? 8'd100 : 8'd0;
  endtask

  task automatic run_pass(input int rmode, input int extra_start, input int start_in_done);
    int cyc;
    logic pv;
    logic [6:0] pidx;
    logic [7:0] pdata;
    nbeats = 0; order_err = 0; stall_err = 0; done_cyc = -1; first_valid = -1;
    beats_at_done = -1; busy_at_done = 1'b0; pv = 1'b0; pidx = '0; pdata = '0; cyc = 0;
    @(negedge clk);
    start = 1;
    f6_ready = 1;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (extra_start != 0) && (cyc == 50 || cyc == 150);
      if (pv && (!f6_valid || f6_idx !== pidx || f6_data !== pdata)) stall_err++;
      if (f6_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        beats_at_done = nbeats;
        busy_at_done = busy;
        start = start_in_done != 0;
      end
      f6_ready = rmode == 0 ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (f6_valid && f6_ready) begin
        if (nbeats < 84) got[nbeats] = f6_data;
        if (int'(f6_idx) != nbeats) order_err++;
        nbeats++;
      end
      pv = f6_valid && !f6_ready;
      pidx = f6_idx;
      pdata = f6_data;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1;
    #2;
    checks++;
    if ({busy, done, f6_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, f6_valid});
    end
    checks++;
    if (f6_idx !== 7'd0 || f6_data !== 8'd0) begin
      failures++; $display("FAIL reset_out got idx=%0d data=%0d exp 0/0", f6_idx, f6_data);
    end
    checks++;
    if (w6_raddr !== 7'd0 || c5_raddr !== 7'd0) begin
      failures++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", w6_raddr, c5_raddr);
    end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_ones;
    set_mode(0);
    run_pass(0, 0, 0);
    checks++;
    if (done_cyc != 207) begin failures++; $display("FAIL ones_done_cycle got=%0d exp=207", done_cyc); end
    checks++;
    if (first_valid != 123) begin failures++; $display("FAIL ones_first_valid got=%0d exp=123", first_valid); end
    checks++;
    if (nbeats != 84 || order_err != 0) begin
      failures++; $display("FAIL ones_beats got=%0d order_err=%0d exp=84/0", nbeats, order_err);
    end
    checks++;
    if (busy_at_done !== 1'b1) begin failures++; $display("FAIL ones_busy_at_done got=%b exp=1", busy_at_done); end
    for (int j = 0; j < 84; j++) begin
      checks++;
      if (got[j] !== 8'sd0) begin failures++; $display("FAIL ones_data[%0d] got=%0d exp=0", j, got[j]); end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ones_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_saturate;
    set_mode(1);
    run_pass(0, 0, 0);
    for (int j = 0; j < 84; j++) begin
      checks++;
      if (got[j] !== 8'sd127) begin failures++; $display("FAIL sat_pos[%0d] got=%0d exp=127", j, got[j]); end
    end
    set_mode(2);
    run_pass(0, 0, 0);
    for (int j = 0; j < 84; j++) begin
      checks++;
      if (got[j] !== -8'sd128) begin failures++; $display("FAIL sat_neg[%0d] got=%0d exp=-128", j, got[j]); end
    end
  endtask

  task automatic test_lanes;
    int e;
    set_mode(3);
    run_pass(0, 0, 0);
    checks++;
    if (got[0] !== -8'sd40 || got[42] !== 8'sd0 || got[83] !== 8'sd38) begin
      failures++; $display("FAIL lanes_spot got=%0d/%0d/%0d exp=-40/0/38", got[0], got[42], got[83]);
    end
    for (int j = 0; j < 84; j++) begin
      e = (120 * (j - 42)) >>> 7;
      checks++;
      if (got[j] !== 8'(e)) begin failures++; $display("FAIL lanes[%0d] got=%0d exp=%0d", j, got[j], e); end
    end
    set_mode(4);
    run_pass(0, 0, 0);
    checks++;
    if (got[0] !== -8'sd66 || got[42] !== 8'sd0 || got[83] !== 8'sd64) begin
      failures++; $display("FAIL ends_spot got=%0d/%0d/%0d exp=-66/0/64", got[0], got[42], got[83]);
    end
  endtask

  task automatic test_backpressure;
    int e;
    set_mode(3);
    run_pass(1, 1, 0);
    checks++;
    if (nbeats != 84 || order_err != 0) begin
      failures++; $display("FAIL bp_beats got=%0d order_err=%0d exp=84/0", nbeats, order_err);
    end
    checks++;
    if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    checks++;
    if (beats_at_done != 84) begin failures++; $display("FAIL bp_done_after_last got=%0d exp=84", beats_at_done); end
    checks++;
    if (done_cyc <= 207) begin failures++; $display("FAIL bp_done_cycle got=%0d exp>207", done_cyc); end
    for (int j = 0; j < 84; j++) begin
      e = (120 * (j - 42)) >>> 7;
      checks++;
      if (got[j] !== 8'(e)) begin failures++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", j, got[j], e); end
    end
  endtask

  task automatic test_restart;
    set_mode(1);
    run_pass(0, 0, 1);
    checks++;
    if (busy_at_done !== 1'b1) begin failures++; $display("FAIL rs_busy_at_done got=%b exp=1", busy_at_done); end
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rs_start_in_done got busy=%b exp=0", busy); end
    set_mode(3);
    run_pass(0, 0, 0);
    checks++;
    if (nbeats != 84 || done_cyc != 207) begin
      failures++; $display("FAIL rs_pass got beats=%0d done=%0d exp=84/207", nbeats, done_cyc);
    end
    checks++;
    if (got[0] !== -8'sd40 || got[42] !== 8'sd0 || got[83] !== 8'sd38) begin
      failures++; $display("FAIL rs_data got=%0d/%0d/%0d exp=-40/0/38", got[0], got[42], got[83]);
    end
  endtask

  task automatic test_reset_mid;
    int vh;
    set_mode(1);
    @(negedge clk);
    start = 1;
    f6_ready = 1;
    repeat (60) begin
      @(negedge clk);
      start = 0;
    end
    checks++;
    if (w6_raddr !== 7'd59 || c5_raddr !== 7'd59 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_addr got=%0d/%0d busy=%b exp=59/59/1", w6_raddr, c5_raddr, busy);
    end
    rst = 1;
    #1;
    checks++;
    if ({busy, done, f6_valid} !== 3'b000 || f6_idx !== 7'd0 || f6_data !== 8'd0) begin
      failures++; $display("FAIL mid_rst_out got=%b idx=%0d data=%0d exp 000/0/0", {busy, done, f6_valid}, f6_idx, f6_data);
    end
    checks++;
    if (w6_raddr !== 7'd0 || c5_raddr !== 7'd0) begin
      failures++; $display("FAIL mid_rst_addr got=%0d/%0d exp=0/0", w6_raddr, c5_raddr);
    end
    @(negedge clk);
    rst = 0;
    vh = 0;
    repeat (20) begin
      @(negedge clk);
      if (f6_valid || done || busy) vh++;
    end
    checks++;
    if (vh != 0) begin failures++; $display("FAIL mid_no_residue_beats got=%0d exp=0", vh); end
    set_mode(4);
    run_pass(0, 0, 0);
    checks++;
    if (nbeats != 84 || got[0] !== -8'sd66 || got[42] !== 8'sd0 || got[83] !== 8'sd64) begin
      failures++; $display("FAIL mid_after got beats=%0d %0d/%0d/%0d exp=84 -66/0/64", nbeats, got[0], got[42], got[83]);
    end
  endtask

  initial begin
    set_mode(0);
    test_reset;
    test_ones;
    test_saturate;
    test_lanes;
    test_backpressure;
    test_restart;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
